// File: rtl/riscv_core_icache_assoc.sv
// Set-associative instruction cache with single-line refill port and fence.i flush.
// Latency: hit response 1 cycle after accept (2 when the fetch straddles two lines).
// Backpressure: o_req_ready low outside IDLE; refill request held until i_refill_valid; no response stall.
module riscv_core_icache_assoc #(
  parameter int WAYS               = 2,
  parameter int INDEX_WIDTH        = 7,
  parameter int BLOCK_OFFSET_WIDTH = 3,
  parameter int ADDR_WIDTH         = 64,
  parameter int AXI_DATA_WIDTH     = 256,
  parameter int CORE_DATA_WIDTH    = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [ADDR_WIDTH-1:0]     i_req_addr,
  output logic                      o_rsp_valid,
  output logic [CORE_DATA_WIDTH-1:0] o_rsp_data,
  output logic                      o_refill_req,
  output logic [ADDR_WIDTH-1:0]     o_refill_addr,
  input  logic                      i_refill_valid,
  input  logic [AXI_DATA_WIDTH-1:0] i_refill_data,
  input  logic                      i_flush,
  output logic                      o_flush_busy
);

  localparam int LINE_OFFSET = BLOCK_OFFSET_WIDTH + 2;
  localparam int LINE_BYTES  = 1 << LINE_OFFSET;
  localparam int CACHE_DEPTH = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - LINE_OFFSET;
  localparam int LINE_WIDTH  = ADDR_WIDTH - LINE_OFFSET;
  localparam int WAY_BITS    = (WAYS > 1) ? $clog2(WAYS) : 1;
  // Offsets above this one run past the end of the line.
  localparam logic [LINE_OFFSET-1:0] LAST_WORD_OFF = LINE_OFFSET'(LINE_BYTES - 4);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_FLUSH} state_t;

  state_t                      state_q;
  logic [ADDR_WIDTH-1:0]       req_addr_q;
  logic                        phase_q;      // 0: low line, 1: next line of a straddling fetch
  logic [31:0]                 low_hi_q;     // top word of the low line, kept for the straddle merge
  logic [INDEX_WIDTH-1:0]      flush_idx_q;
  logic                        ready_q;
  logic                        rsp_valid_q;
  logic [CORE_DATA_WIDTH-1:0]  rsp_data_q;
  logic                        refill_req_q;
  logic [ADDR_WIDTH-1:0]       refill_addr_q;
  logic                        flush_busy_q;

  logic [WAYS-1:0]             valid_q  [CACHE_DEPTH];
  logic [WAY_BITS-1:0]         ptr_q    [CACHE_DEPTH];
  logic [TAG_WIDTH-1:0]        tag_mem  [WAYS][CACHE_DEPTH];
  logic [AXI_DATA_WIDTH-1:0]   data_mem [WAYS][CACHE_DEPTH];

  logic [LINE_OFFSET-1:0]      line_off;
  logic                        straddle;
  logic [LINE_WIDTH-1:0]       lo_line;
  logic [LINE_WIDTH-1:0]       cur_line;
  logic [INDEX_WIDTH-1:0]      cur_idx;
  logic [TAG_WIDTH-1:0]        cur_tag;
  logic                        hit_any;
  logic [AXI_DATA_WIDTH-1:0]   hit_line;
  logic [WAY_BITS-1:0]         victim;
  logic [WAY_BITS-1:0]         ptr_next;
  logic [CORE_DATA_WIDTH-1:0]  word_single;
  logic [CORE_DATA_WIDTH-1:0]  word_merged;

  assign o_req_ready   = ready_q && !i_flush;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_refill_req  = refill_req_q;
  assign o_refill_addr = refill_addr_q;
  assign o_flush_busy  = flush_busy_q;

  assign line_off = req_addr_q[LINE_OFFSET-1:0];
  assign straddle = line_off > LAST_WORD_OFF;
  assign lo_line  = req_addr_q[ADDR_WIDTH-1:LINE_OFFSET];
  assign cur_line = phase_q ? lo_line + LINE_WIDTH'(1) : lo_line;
  assign cur_idx  = cur_line[INDEX_WIDTH-1:0];
  assign cur_tag  = cur_line[LINE_WIDTH-1:INDEX_WIDTH];
  assign ptr_next = (ptr_q[cur_idx] == WAY_BITS'(WAYS - 1)) ? '0 : ptr_q[cur_idx] + WAY_BITS'(1);

  // Fetch word within one line, and the two-line merge (low-line tail then next-line head).
  assign word_single = CORE_DATA_WIDTH'(hit_line >> {line_off, 3'b000});
  assign word_merged = CORE_DATA_WIDTH'({hit_line[31:0], low_hi_q} >> {line_off[1:0], 3'b000});

  // Parallel tag compare across all ways of the current set.
  always_comb begin
    hit_any  = 1'b0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[cur_idx][w] && (tag_mem[w][cur_idx] == cur_tag)) begin
        hit_any  = 1'b1;
        hit_line = data_mem[w][cur_idx];
      end
    end
  end

  // Victim: lowest invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    victim = ptr_q[cur_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[cur_idx][w]) victim = WAY_BITS'(w);
    end
  end

  // Line and tag storage; not reset, contents are meaningless until the valid bit is set.
  always_ff @(posedge i_clk) begin
    if (state_q == S_REFILL && i_refill_valid) begin
      data_mem[victim][cur_idx] <= i_refill_data;
      tag_mem[victim][cur_idx]  <= cur_tag;
    end
  end

  // Control FSM with registered outputs, plus valid bits and replacement pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      req_addr_q    <= '0;
      phase_q       <= 1'b0;
      low_hi_q      <= '0;
      flush_idx_q   <= '0;
      ready_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      refill_req_q  <= 1'b0;
      refill_addr_q <= '0;
      flush_busy_q  <= 1'b0;
      for (int s = 0; s < CACHE_DEPTH; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_flush) begin
            state_q      <= S_FLUSH;
            ready_q      <= 1'b0;
            flush_busy_q <= 1'b1;
            flush_idx_q  <= '0;
          end else if (i_req_valid && ready_q) begin
            state_q    <= S_LOOKUP;
            ready_q    <= 1'b0;
            req_addr_q <= i_req_addr & ~ADDR_WIDTH'(1);
            phase_q    <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_LOOKUP: begin
          if (!hit_any) begin
            state_q       <= S_REFILL;
            refill_req_q  <= 1'b1;
            refill_addr_q <= {cur_line, LINE_OFFSET'(0)};
          end else if (straddle && !phase_q) begin
            low_hi_q <= hit_line[AXI_DATA_WIDTH-1 -: 32];
            phase_q  <= 1'b1;
          end else begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= straddle ? word_merged : word_single;
          end
        end
        S_REFILL: begin
          if (i_refill_valid) begin
            valid_q[cur_idx][victim] <= 1'b1;
            ptr_q[cur_idx]           <= ptr_next;
            refill_req_q             <= 1'b0;
            state_q                  <= S_LOOKUP;
          end
        end
        S_FLUSH: begin
          valid_q[flush_idx_q] <= '0;
          ptr_q[flush_idx_q]   <= '0;
          if (flush_idx_q == INDEX_WIDTH'(CACHE_DEPTH - 1)) begin
            state_q      <= S_IDLE;
            flush_busy_q <= 1'b0;
            ready_q      <= 1'b1;
          end else begin
            flush_idx_q <= flush_idx_q + INDEX_WIDTH'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
